// File: rtl/vlsu_addr_gen_if.sv
// Scheduler-side bus of the vector load/store address generator:
// two lane addresses with enables and access type, plus per-lane arrival and fault feedback.
interface vlsu_addr_gen_if;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic        lane_en0;
  logic        lane_en1;
  logic        mem_load;
  logic        mem_store;
  logic        arrived0;
  logic        arrived1;
  logic        exception;

  modport master (
    output addr0, addr1, lane_en0, lane_en1, mem_load, mem_store,
    input  arrived0, arrived1, exception
  );

  modport slave (
    input  addr0, addr1, lane_en0, lane_en1, mem_load, mem_store,
    output arrived0, arrived1, exception
  );
endinterface

// File: rtl/vlsu_addr_gen.sv
// Vector load/store address generator: walks a unit-stride or strided op two elements
// per step, holding each address pair until both lanes have arrived at the scheduler.
module vlsu_addr_gen #(
  parameter int VL_W = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              load,
  input  logic              store,
  input  logic [31:0]       base_addr,
  input  logic [31:0]       stride,
  input  logic              strided,
  input  logic [1:0]        sew,
  input  logic [VL_W-1:0]   vl,
  vlsu_addr_gen_if.master   sched,
  output logic [VL_W-1:0]   elem_idx,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [VL_W-1:0]   fault_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Index arithmetic is one bit wider so idx+2 cannot wrap past vl.
  localparam logic [VL_W:0] ONE_E = {{VL_W{1'b0}}, 1'b1};
  localparam logic [VL_W:0] TWO_E = {{(VL_W-1){1'b0}}, 2'b10};

  state_t            state_r, state_s;
  logic [31:0]       cur_addr_r, cur_addr_s;
  logic [31:0]       step_r, step_s;
  logic [VL_W-1:0]   idx_r, idx_s;
  logic [VL_W-1:0]   vl_r, vl_s;
  logic              is_load_r, is_load_s;
  logic              got0_r, got0_s;
  logic              got1_r, got1_s;

  logic [31:0]       addr0_r, addr0_s;
  logic [31:0]       addr1_r, addr1_s;
  logic              lane_en0_r, lane_en0_s;
  logic              lane_en1_r, lane_en1_s;
  logic              mem_load_r, mem_load_s;
  logic              mem_store_r, mem_store_s;
  logic [VL_W-1:0]   elem_idx_r, elem_idx_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              fault_r, fault_s;
  logic [VL_W-1:0]   fault_idx_r, fault_idx_s;

  logic              g0_s;
  logic              g1_s;
  logic              run_s;
  logic              accept_s;
  logic [VL_W:0]     idx_p2_s;

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    step_s      = step_r;
    idx_s       = idx_r;
    vl_s        = vl_r;
    is_load_s   = is_load_r;
    got0_s      = got0_r;
    got1_s      = got1_r;
    fault_s     = 1'b0;
    fault_idx_s = fault_idx_r;

    accept_s = start & (load ^ store) & (sew != 2'd3);
    g0_s     = got0_r | sched.arrived0;
    g1_s     = got1_r | (sched.arrived1 & lane_en1_r) | ~lane_en1_r;
    idx_p2_s = {1'b0, idx_r} + TWO_E;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          fault_idx_s = {VL_W{1'b0}};
          if (vl == {VL_W{1'b0}}) begin
            state_s = FIN;
          end else begin
            state_s    = RUN;
            is_load_s  = load;
            vl_s       = vl;
            cur_addr_s = base_addr;
            step_s     = strided ? stride : (32'd1 << sew);
            idx_s      = {VL_W{1'b0}};
            got0_s     = 1'b0;
            got1_s     = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // An exception wins over a pair completing in the same cycle.
        if (sched.exception) begin
          state_s     = FIN;
          fault_s     = 1'b1;
          fault_idx_s = g0_s ? (idx_r + ONE_E[VL_W-1:0]) : idx_r;
        end else if (g0_s && g1_s) begin
          if (idx_p2_s >= {1'b0, vl_r}) begin
            state_s = FIN;
          end else begin
            cur_addr_s = cur_addr_r + {step_r[30:0], 1'b0};
            idx_s      = idx_p2_s[VL_W-1:0];
            got0_s     = 1'b0;
            got1_s     = 1'b0;
          end
        end else begin
          got0_s = g0_s;
          got1_s = g1_s;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are a registered image of the state being entered.
    run_s       = (state_s == RUN);
    addr0_s     = run_s ? cur_addr_s : 32'd0;
    addr1_s     = run_s ? (cur_addr_s + step_s) : 32'd0;
    lane_en0_s  = run_s;
    lane_en1_s  = run_s & (({1'b0, idx_s} + ONE_E) < {1'b0, vl_s});
    mem_load_s  = run_s & is_load_s;
    mem_store_s = run_s & ~is_load_s;
    elem_idx_s  = run_s ? idx_s : {VL_W{1'b0}};
    busy_s      = run_s;
    done_s      = (state_s == FIN);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      cur_addr_r  <= 32'd0;
      step_r      <= 32'd0;
      idx_r       <= {VL_W{1'b0}};
      vl_r        <= {VL_W{1'b0}};
      is_load_r   <= 1'b0;
      got0_r      <= 1'b0;
      got1_r      <= 1'b0;
      addr0_r     <= 32'd0;
      addr1_r     <= 32'd0;
      lane_en0_r  <= 1'b0;
      lane_en1_r  <= 1'b0;
      mem_load_r  <= 1'b0;
      mem_store_r <= 1'b0;
      elem_idx_r  <= {VL_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      fault_idx_r <= {VL_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      step_r      <= step_s;
      idx_r       <= idx_s;
      vl_r        <= vl_s;
      is_load_r   <= is_load_s;
      got0_r      <= got0_s;
      got1_r      <= got1_s;
      addr0_r     <= addr0_s;
      addr1_r     <= addr1_s;
      lane_en0_r  <= lane_en0_s;
      lane_en1_r  <= lane_en1_s;
      mem_load_r  <= mem_load_s;
      mem_store_r <= mem_store_s;
      elem_idx_r  <= elem_idx_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      fault_r     <= fault_s;
      fault_idx_r <= fault_idx_s;
    end
  end

  assign sched.addr0     = addr0_r;
  assign sched.addr1     = addr1_r;
  assign sched.lane_en0  = lane_en0_r;
  assign sched.lane_en1  = lane_en1_r;
  assign sched.mem_load  = mem_load_r;
  assign sched.mem_store = mem_store_r;
  assign elem_idx        = elem_idx_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign fault           = fault_r;
  assign fault_idx       = fault_idx_r;

endmodule

// File: tb/tb_vlsu_addr_gen.sv
// Directed scoreboard bench for vlsu_addr_gen: expected address pairs are queued when an
// op is issued and popped as the generator presents each pair.
module tb_vlsu_addr_gen;
  localparam int VL_W = 6;

  logic            clk = 1'b0;
  logic            nrst;
  logic            start, load, store, strided;
  logic [31:0]     base_addr, stride;
  logic [1:0]      sew;
  logic [VL_W-1:0] vl;
  logic [VL_W-1:0] elem_idx, fault_idx;
  logic            busy, done, fault;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [31:0]     a0;
    logic [31:0]     a1;
    logic            en1;
    logic [VL_W-1:0] idx;
    logic            ld;
    logic            st;
  } exp_t;

  exp_t exp_q[$];

  vlsu_addr_gen_if sif ();

  vlsu_addr_gen #(.VL_W(VL_W)) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .start     (start),
    .load      (load),
    .store     (store),
    .base_addr (base_addr),
    .stride    (stride),
    .strided   (strided),
    .sew       (sew),
    .vl        (vl),
    .sched     (sif.master),
    .elem_idx  (elem_idx),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .fault_idx (fault_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bench model of one op: element i sits at base + i*step.
  task automatic push_op(input logic [31:0] base, input logic [31:0] step,
                         input int n, input logic ld);
    exp_t e;
    for (int i = 0; i < n; i += 2) begin
      e.a0  = base + step * 32'(i);
      e.a1  = e.a0 + step;
      e.en1 = (i + 1 < n);
      e.idx = VL_W'(i);
      e.ld  = ld;
      e.st  = ~ld;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_pair();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("lane_en0", {31'd0, sif.lane_en0}, 32'd1);
      chk("addr0", sif.addr0, e.a0);
      chk("addr1", sif.addr1, e.a1);
      chk("lane_en1", {31'd0, sif.lane_en1}, {31'd0, e.en1});
      chk("elem_idx", 32'(elem_idx), 32'(e.idx));
      chk("mem_load", {31'd0, sif.mem_load}, {31'd0, e.ld});
      chk("mem_store", {31'd0, sif.mem_store}, {31'd0, e.st});
      chk("busy_run", {31'd0, busy}, 32'd1);
    end
  endtask

  // Answer every queued pair with both lanes arriving together, then expect the done pulse.
  task automatic serve();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      check_pair();
      sif.arrived0 = 1'b1;
      sif.arrived1 = 1'b1;
      tick();
      sif.arrived0 = 1'b0;
      sif.arrived1 = 1'b0;
      guard++;
    end
    chk("serve_bound", 32'(exp_q.size()), 32'd0);
    chk("done", {31'd0, done}, 32'd1);
    chk("fault_clean", {31'd0, fault}, 32'd0);
    chk("busy_fin", {31'd0, busy}, 32'd0);
    chk("lane_en0_fin", {31'd0, sif.lane_en0}, 32'd0);
    chk("mem_load_fin", {31'd0, sif.mem_load}, 32'd0);
    chk("mem_store_fin", {31'd0, sif.mem_store}, 32'd0);
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [31:0] base,
                       input logic [31:0] strd, input logic is_str,
                       input logic [1:0] s, input logic [VL_W-1:0] n);
    load      = ld;
    store     = st;
    base_addr = base;
    stride    = strd;
    strided   = is_str;
    sew       = s;
    vl        = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0; load = 1'b0; store = 1'b0; strided = 1'b0;
    base_addr = 32'd0; stride = 32'd0; sew = 2'd0; vl = '0;
    sif.arrived0 = 1'b0; sif.arrived1 = 1'b0; sif.exception = 1'b0;
    #1;
    chk("rst_addr0", sif.addr0, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault_idx", 32'(fault_idx), 32'd0);
    tick();
    tick();
    nrst = 1'b1;
    tick();

    // Unit-stride SEW32 load, vl=5.
    push_op(32'h1000, 32'd4, 5, 1'b1);
    issue(1'b1, 1'b0, 32'h1000, 32'd0, 1'b0, 2'd2, 6'd5);
    serve();

    // Strided SEW8 store, negative stride, lanes arriving on separate cycles.
    push_op(32'h20, 32'hFFFF_FFFC, 2, 1'b0);
    issue(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFC, 1'b1, 2'd0, 6'd2);
    check_pair();
    tick();
    sif.arrived1 = 1'b1;
    tick();
    sif.arrived1 = 1'b0;
    chk("t2_hold_addr0", sif.addr0, 32'h20);
    chk("t2_hold_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t2_hold2_done", {31'd0, done}, 32'd0);
    sif.arrived0 = 1'b1;
    tick();
    sif.arrived0 = 1'b0;
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_fault", {31'd0, fault}, 32'd0);
    tick();

    // Unit-stride SEW16 load, exception after lane 0 of the second pair.
    push_op(32'h200, 32'd2, 4, 1'b1);
    issue(1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 2'd1, 6'd8);
    check_pair();
    sif.arrived0 = 1'b1;
    sif.arrived1 = 1'b1;
    tick();
    sif.arrived1 = 1'b0;
    check_pair();
    tick();
    sif.arrived0 = 1'b0;
    sif.exception = 1'b1;
    tick();
    sif.exception = 1'b0;
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_fault", {31'd0, fault}, 32'd1);
    chk("t3_fault_idx", 32'(fault_idx), 32'd3);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t3_fault_pulse", {31'd0, fault}, 32'd0);
    chk("t3_fault_idx_hold", 32'(fault_idx), 32'd3);

    // vl=0 finishes without RUN; illegal requests are ignored.
    issue(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 2'd2, 6'd0);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_mem_load", {31'd0, sif.mem_load}, 32'd0);
    chk("t4_fault_idx_clr", 32'(fault_idx), 32'd0);
    tick();
    chk("t4_done_pulse", {31'd0, done}, 32'd0);
    issue(1'b1, 1'b1, 32'h40, 32'd0, 1'b0, 2'd2, 6'd4);
    chk("t4_both_busy", {31'd0, busy}, 32'd0);
    chk("t4_both_mem", {30'd0, sif.mem_load, sif.mem_store}, 32'd0);
    issue(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 2'd3, 6'd4);
    chk("t4_sew3_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t4_sew3_done", {31'd0, done}, 32'd0);

    // Address wrap-around.
    push_op(32'hFFFF_FFFC, 32'd4, 3, 1'b1);
    issue(1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0, 2'd2, 6'd3);
    serve();

    // Reset in RUN with lane 0 already arrived.
    push_op(32'h3000, 32'd4, 2, 1'b1);
    issue(1'b1, 1'b0, 32'h3000, 32'd0, 1'b0, 2'd2, 6'd6);
    check_pair();
    sif.arrived0 = 1'b1;
    tick();
    sif.arrived0 = 1'b0;
    nrst = 1'b0;
    #1;
    chk("t6_rst_lane_en0", {31'd0, sif.lane_en0}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_addr0", sif.addr0, 32'd0);
    chk("t6_rst_mem_load", {31'd0, sif.mem_load}, 32'd0);
    tick();
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    nrst = 1'b1;
    tick();
    chk("t6_after_done", {31'd0, done}, 32'd0);
    push_op(32'h5000, 32'd2, 3, 1'b0);
    issue(1'b0, 1'b1, 32'h5000, 32'd0, 1'b0, 2'd1, 6'd3);
    serve();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
